// File: rtl/trap_ctrl_pkg.sv
// rtl/trap_ctrl_pkg.sv - shared exception indices, cause codes and trap FSM states
package trap_ctrl_pkg;

    localparam int EXC_NUM = 9;

    // Bit positions of exc_req, listed from highest to lowest priority
    typedef enum logic [3:0] {
        EXC_INSTR_ACCESS   = 4'd0,
        EXC_ILLEGAL        = 4'd1,
        EXC_INSTR_MISALIGN = 4'd2,
        EXC_ECALL_M        = 4'd3,
        EXC_EBREAK         = 4'd4,
        EXC_LOAD_MISALIGN  = 4'd5,
        EXC_STORE_MISALIGN = 4'd6,
        EXC_LOAD_ACCESS    = 4'd7,
        EXC_STORE_ACCESS   = 4'd8
    } exc_idx_e;

    // RISC-V mcause exception codes (no interrupt flag)
    localparam logic [3:0] CAUSE_INSTR_MISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_INSTR_ACCESS   = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT     = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_ACCESS    = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_STORE_ACCESS   = 4'd7;
    localparam logic [3:0] CAUSE_ECALL_M        = 4'd11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT     = 2'd2,
        REDIRECT = 2'd3
    } trap_state_e;

    // Which retiring-instruction field becomes mtval
    typedef enum logic [1:0] {
        TVAL_ZERO  = 2'd0,
        TVAL_PC    = 2'd1,
        TVAL_INSTR = 2'd2,
        TVAL_ADDR  = 2'd3
    } tval_sel_e;

endpackage

// File: rtl/trap_ctrl_if.sv
// rtl/trap_ctrl_if.sv - trap handshake between trap_ctrl and csrfile
interface trap_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  trap;
    logic [3:0]            trap_cause;
    logic [DATA_WIDTH-1:0] trap_value;
    logic [DATA_WIDTH-1:0] trap_pc;
    logic                  trap_handled;
    logic [DATA_WIDTH-1:0] trap_target_pc;

    // master: trap_ctrl side
    modport master (
        output trap, trap_cause, trap_value, trap_pc,
        input  trap_handled, trap_target_pc
    );

    // slave: csrfile side
    modport slave (
        input  trap, trap_cause, trap_value, trap_pc,
        output trap_handled, trap_target_pc
    );
endinterface

// File: rtl/trap_ctrl_exc_prio_enc.sv
// rtl/trap_ctrl_exc_prio_enc.sv - priority encoder picking one exception from exc_req
module trap_ctrl_exc_prio_enc
    import trap_ctrl_pkg::*;
(
    input  logic [EXC_NUM-1:0] exc_req,
    output logic               hit,
    output logic [3:0]         cause,
    output tval_sel_e          tval_sel
);

    // First set bit in priority order wins; lower ones are discarded
    always_comb begin
        hit      = |exc_req;
        cause    = CAUSE_INSTR_MISALIGN;
        tval_sel = TVAL_ZERO;
        if (exc_req[EXC_INSTR_ACCESS]) begin
            cause    = CAUSE_INSTR_ACCESS;
            tval_sel = TVAL_PC;
        end else if (exc_req[EXC_ILLEGAL]) begin
            cause    = CAUSE_ILLEGAL;
            tval_sel = TVAL_INSTR;
        end else if (exc_req[EXC_INSTR_MISALIGN]) begin
            cause    = CAUSE_INSTR_MISALIGN;
            tval_sel = TVAL_ADDR;
        end else if (exc_req[EXC_ECALL_M]) begin
            cause    = CAUSE_ECALL_M;
            tval_sel = TVAL_ZERO;
        end else if (exc_req[EXC_EBREAK]) begin
            cause    = CAUSE_BREAKPOINT;
            tval_sel = TVAL_PC;
        end else if (exc_req[EXC_LOAD_MISALIGN]) begin
            cause    = CAUSE_LOAD_MISALIGN;
            tval_sel = TVAL_ADDR;
        end else if (exc_req[EXC_STORE_MISALIGN]) begin
            cause    = CAUSE_STORE_MISALIGN;
            tval_sel = TVAL_ADDR;
        end else if (exc_req[EXC_LOAD_ACCESS]) begin
            cause    = CAUSE_LOAD_ACCESS;
            tval_sel = TVAL_ADDR;
        end else if (exc_req[EXC_STORE_ACCESS]) begin
            cause    = CAUSE_STORE_ACCESS;
            tval_sel = TVAL_ADDR;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - exception arbitration, trap issue to csrfile and fetch redirect
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  exc_valid,
    input  logic [EXC_NUM-1:0]    exc_req,
    input  logic [DATA_WIDTH-1:0] exc_pc,
    input  logic [DATA_WIDTH-1:0] exc_instr,
    input  logic [DATA_WIDTH-1:0] exc_addr,
    trap_ctrl_if.master           csr,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  flush,
    output logic                  stall,
    output logic                  csr_block,
    output logic                  trap_err
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    trap_state_e           state;
    logic [CNT_W-1:0]      ack_cnt;
    logic                  hit;
    logic [3:0]            win_cause;
    tval_sel_e             tval_sel;
    logic [DATA_WIDTH-1:0] win_tval;

    trap_ctrl_exc_prio_enc u_prio (
        .exc_req  (exc_req),
        .hit      (hit),
        .cause    (win_cause),
        .tval_sel (tval_sel)
    );

    // Select the tval source chosen by the encoder
    always_comb begin
        win_tval = '0;
        case (tval_sel)
            TVAL_PC:    win_tval = exc_pc;
            TVAL_INSTR: win_tval = exc_instr;
            TVAL_ADDR:  win_tval = exc_addr;
            default:    win_tval = '0;
        endcase
    end

    // Trap FSM; every output is registered so trap and redirect are clean single-cycle pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            ack_cnt        <= '0;
            csr.trap       <= 1'b0;
            csr.trap_cause <= '0;
            csr.trap_value <= '0;
            csr.trap_pc    <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            stall          <= 1'b0;
            csr_block      <= 1'b0;
            trap_err       <= 1'b0;
        end else begin
            csr.trap       <= 1'b0;
            redirect_valid <= 1'b0;
            flush          <= 1'b0;
            case (state)
                IDLE: begin
                    if (exc_valid && hit) begin
                        state          <= ISSUE;
                        csr.trap       <= 1'b1;
                        csr.trap_cause <= win_cause;
                        csr.trap_value <= win_tval;
                        csr.trap_pc    <= exc_pc;
                        stall          <= 1'b1;
                        csr_block      <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (csr.trap_handled) begin
                        state          <= REDIRECT;
                        redirect_pc    <= {csr.trap_target_pc[DATA_WIDTH-1:2], 2'b00};
                        redirect_valid <= 1'b1;
                        flush          <= 1'b1;
                    end else if (ack_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                        // csrfile never answered: redirect to 0 and flag it until reset
                        state          <= REDIRECT;
                        trap_err       <= 1'b1;
                        redirect_pc    <= '0;
                        redirect_valid <= 1'b1;
                        flush          <= 1'b1;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                REDIRECT: begin
                    state     <= IDLE;
                    ack_cnt   <= '0;
                    stall     <= 1'b0;
                    csr_block <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - scoreboard bench for trap_ctrl
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    localparam int DW = 32;

    typedef struct {
        logic [3:0]    cause;
        logic [DW-1:0] value;
        logic [DW-1:0] pc;
    } trap_exp_t;

    typedef struct {
        logic [DW-1:0] pc;
        int            lat;
    } redir_exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           exc_valid;
    logic [8:0]     exc_req;
    logic [DW-1:0]  exc_pc, exc_instr, exc_addr;
    logic           redirect_valid, flush, stall, csr_block, trap_err;
    logic [DW-1:0]  redirect_pc;

    trap_ctrl_if #(.DATA_WIDTH(DW)) tif ();

    trap_ctrl #(.DATA_WIDTH(DW), .ACK_TIMEOUT(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .exc_valid      (exc_valid),
        .exc_req        (exc_req),
        .exc_pc         (exc_pc),
        .exc_instr      (exc_instr),
        .exc_addr       (exc_addr),
        .csr            (tif),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .stall          (stall),
        .csr_block      (csr_block),
        .trap_err       (trap_err)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         trap_cyc = 0;
    int         ack_delay = 1;
    logic [DW-1:0] ack_target = '0;
    trap_exp_t  trap_q[$];
    redir_exp_t redir_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // csrfile model: acks ack_delay cycles after seeing the trap pulse (0 = never)
    bit pend = 0;
    int wait_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0;
            tif.trap_handled = 1'b0;
            tif.trap_target_pc = '0;
        end else begin
            tif.trap_handled = 1'b0;
            if (pend) begin
                if (wait_cnt == 0) begin
                    tif.trap_handled = 1'b1;
                    tif.trap_target_pc = ack_target;
                    pend = 0;
                end else begin
                    wait_cnt--;
                end
            end
            if (tif.trap && ack_delay > 0) begin
                pend = 1;
                wait_cnt = ack_delay - 1;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT pulses trap or redirect
    bit in_flight = 0;
    bit prev_trap = 0;
    always @(negedge clk) begin
        trap_exp_t  te;
        redir_exp_t re;
        if (!rst_n) begin
            in_flight = 0;
            prev_trap = 0;
        end else begin
            chk("stall", stall, tif.trap | in_flight);
            chk("csr_block", csr_block, stall);
            chk("flush", flush, redirect_valid);
            if (tif.trap) begin
                chk("trap_single", prev_trap, 1'b0);
                if (trap_q.size() == 0) begin
                    chk("unexpected_trap", 1'b1, 1'b0);
                end else begin
                    te = trap_q.pop_front();
                    chk("trap_cause", tif.trap_cause, te.cause);
                    chk("trap_value", tif.trap_value, te.value);
                    chk("trap_pc", tif.trap_pc, te.pc);
                end
                trap_cyc = cyc;
                in_flight = 1;
            end
            if (redirect_valid) begin
                if (redir_q.size() == 0) begin
                    chk("unexpected_redirect", 1'b1, 1'b0);
                end else begin
                    re = redir_q.pop_front();
                    chk("redirect_pc", redirect_pc, re.pc);
                    chk("redirect_latency", cyc - trap_cyc, re.lat);
                end
                in_flight = 0;
            end
            prev_trap = tif.trap;
        end
    end

    task automatic push_trap(input logic [3:0] c, input logic [DW-1:0] v, input logic [DW-1:0] p);
        trap_exp_t t;
        t.cause = c; t.value = v; t.pc = p;
        trap_q.push_back(t);
    endtask

    task automatic push_redir(input logic [DW-1:0] p, input int lat);
        redir_exp_t r;
        r.pc = p; r.lat = lat;
        redir_q.push_back(r);
    endtask

    task automatic send(input logic [8:0] req, input logic [DW-1:0] pc,
                        input logic [DW-1:0] instr, input logic [DW-1:0] addr);
        @(negedge clk);
        exc_valid = 1'b1; exc_req = req; exc_pc = pc; exc_instr = instr; exc_addr = addr;
        @(negedge clk);
        exc_valid = 1'b0; exc_req = '0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {tif.trap, tif.trap_cause, redirect_valid, flush, stall, csr_block, trap_err}, '0);
        chk({nm, "_buses"}, {tif.trap_value, tif.trap_pc}, '0);
        chk({nm, "_rpc"}, redirect_pc, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        exc_valid = 1'b0; exc_req = '0; exc_pc = '0; exc_instr = '0; exc_addr = '0;
        repeat (3) @(negedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single illegal instruction, nominal ack
        ack_delay = 1; ack_target = 32'h203;
        push_trap(CAUSE_ILLEGAL, 32'hFFFF_FFFF, 32'h100);
        push_redir(32'h200, 2);
        send(9'(1 << EXC_ILLEGAL), 32'h100, 32'hFFFF_FFFF, 32'h55);
        repeat (6) @(negedge clk);

        // Three simultaneous requests: instruction access fault wins
        ack_target = 32'h400;
        push_trap(CAUSE_INSTR_ACCESS, 32'h300, 32'h300);
        push_redir(32'h400, 2);
        send(9'((1 << EXC_ECALL_M) | (1 << EXC_LOAD_MISALIGN) | (1 << EXC_INSTR_ACCESS)),
             32'h300, 32'h73, 32'h1234);
        repeat (6) @(negedge clk);

        // exc_req without exc_valid is ignored
        exc_req = 9'(1 << EXC_ILLEGAL);
        repeat (3) @(negedge clk);
        exc_req = '0;

        // Second request during WAIT is dropped; slower ack
        ack_delay = 3; ack_target = 32'h6001;
        push_trap(CAUSE_BREAKPOINT, 32'h500, 32'h500);
        push_redir(32'h6000, 4);
        send(9'(1 << EXC_EBREAK), 32'h500, 32'h0, 32'h0);
        send(9'(1 << EXC_ECALL_M), 32'h504, 32'h0, 32'h0);
        repeat (6) @(negedge clk);
        chk("no_err_yet", trap_err, 1'b0);

        // Ack never arrives: timeout after 8 WAIT cycles
        ack_delay = 0;
        push_trap(CAUSE_LOAD_MISALIGN, 32'h11, 32'h700);
        push_redir(32'h0, 9);
        send(9'(1 << EXC_LOAD_MISALIGN), 32'h700, 32'h0, 32'h11);
        repeat (12) @(negedge clk);
        chk("trap_err_set", trap_err, 1'b1);

        // Normal trap afterwards; trap_err stays sticky
        ack_delay = 1; ack_target = 32'hA10;
        push_trap(CAUSE_INSTR_MISALIGN, 32'h902, 32'h900);
        push_redir(32'hA10, 2);
        send(9'(1 << EXC_INSTR_MISALIGN), 32'h900, 32'h0, 32'h902);
        repeat (6) @(negedge clk);
        chk("trap_err_sticky", trap_err, 1'b1);

        // Reset while in WAIT abandons the trap
        ack_delay = 0;
        push_trap(CAUSE_ECALL_M, 32'h0, 32'hA00);
        send(9'(1 << EXC_ECALL_M), 32'hA00, 32'h73, 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1 chk_all_zero("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("no_redirect_after_reset", redir_q.size(), 0);
        chk("idle_after_reset", {stall, trap_err}, 2'b00);

        // Back-to-back load access then store misalign
        ack_delay = 1; ack_target = 32'hC00;
        push_trap(CAUSE_LOAD_ACCESS, 32'h8000_0001, 32'hB00);
        push_redir(32'hC00, 2);
        send(9'(1 << EXC_LOAD_ACCESS), 32'hB00, 32'h0, 32'h8000_0001);
        repeat (4) @(negedge clk);
        push_trap(CAUSE_STORE_MISALIGN, 32'h8000_0006, 32'hB04);
        push_redir(32'hC00, 2);
        send(9'(1 << EXC_STORE_MISALIGN), 32'hB04, 32'h0, 32'h8000_0006);
        repeat (6) @(negedge clk);

        // Lowest priority alone
        ack_target = 32'hD07;
        push_trap(CAUSE_STORE_ACCESS, 32'hEE0, 32'hD00);
        push_redir(32'hD04, 2);
        send(9'(1 << EXC_STORE_ACCESS), 32'hD00, 32'h0, 32'hEE0);
        repeat (6) @(negedge clk);

        chk("trap_q_drained", trap_q.size(), 0);
        chk("redir_q_drained", redir_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
